box5_window_filter: RTL and testbench



---
 rtl/box5_window_filter_if.sv | 41 ++++
 rtl/box5_window_filter.sv | 135 +++++++++++++
 tb/tb_box5_window_filter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/box5_window_filter_if.sv
// box5_window_filter_if: column-in / filtered-pixel-out stream bundle for box5_window_filter.
// With BOX5_CENTER_BYPASS_EN defined, a per-column bypass flag rides with the input column.
interface box5_window_filter_if #(
    parameter int pix_depth = 4
);
    logic                 s_tvalid;
    logic                 s_tready;
    logic [1:0]           s_tuser;
    logic [pix_depth-1:0] in_d0;
    logic [pix_depth-1:0] in_d1;
    logic [pix_depth-1:0] in_d2;
    logic [pix_depth-1:0] in_d3;
    logic [pix_depth-1:0] in_d4;
`ifdef BOX5_CENTER_BYPASS_EN
    logic                 bypass;
`endif
    logic                 m_tvalid;
    logic                 m_tready;
    logic [pix_depth-1:0] m_tdata;
    logic [1:0]           m_tuser;

`ifdef BOX5_CENTER_BYPASS_EN
    modport master (
        output s_tvalid, s_tuser, in_d0, in_d1, in_d2, in_d3, in_d4, bypass, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tuser
    );
    modport slave (
        input  s_tvalid, s_tuser, in_d0, in_d1, in_d2, in_d3, in_d4, bypass, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tuser
    );
`else
    modport master (
        output s_tvalid, s_tuser, in_d0, in_d1, in_d2, in_d3, in_d4, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tuser
    );
    modport slave (
        input  s_tvalid, s_tuser, in_d0, in_d1, in_d2, in_d3, in_d4, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tuser
    );
`endif
endinterface

// File: rtl/box5_window_filter.sv
// box5_window_filter: 5x5 box filter over a pre-padded column stream, emits floor(sum/25).
// Optional BOX5_CENTER_BYPASS_EN: per-column bypass outputs the window centre pixel instead.
module box5_window_filter #(
    parameter int pix_depth   = 4,
    parameter int frame_width = 10,
    parameter int filter_size = 5,
    parameter int add_cells   = (filter_size - 1) / 2
) (
    input logic                 clk,
    input logic                 resetn,
    box5_window_filter_if.slave bus
);
    localparam int LINE_W = frame_width + 2 * add_cells;
    localparam int COL_W  = $clog2(LINE_W);
    localparam int CS_W   = pix_depth + 3;
    localparam int WS_W   = pix_depth + 5;

    generate
        if (filter_size != 5) begin : g_size_check
            $error("box5_window_filter: filter_size must be 5");
        end
    endgenerate

    logic                 en;
    logic                 accept;
    logic                 line_end;
    logic                 win_full;
    logic                 pend_next;
    logic                 pending_sof;
    logic [COL_W-1:0]     col;
    logic [COL_W-1:0]     col_eff;
    logic [CS_W-1:0]      cs;
    logic [WS_W-1:0]      ws;
    logic [pix_depth-1:0] q_next;

    logic [4:0][CS_W-1:0] cs_win;
    logic                 s1_valid;
    logic [1:0]           s1_user;
    logic [WS_W-1:0]      ws_r;
    logic                 s2_valid;
    logic [1:0]           s2_user;
    logic [pix_depth-1:0] q_r;
    logic                 s3_valid;
    logic [1:0]           s3_user;
    logic [pix_depth-1:0] m_data_r;
    logic                 m_valid_r;
    logic [1:0]           m_user_r;

`ifdef BOX5_CENTER_BYPASS_EN
    logic [2:0][pix_depth-1:0] ctr_win;
    logic                      s1_byp;
    logic                      s2_byp;
    logic [pix_depth-1:0]      s2_ctr;
`endif

    always_comb begin
        en        = !m_valid_r | bus.m_tready;
        accept    = bus.s_tvalid & en;
        cs        = CS_W'(bus.in_d0) + CS_W'(bus.in_d1) + CS_W'(bus.in_d2)
                  + CS_W'(bus.in_d3) + CS_W'(bus.in_d4);
        // An SOF column always starts a fresh line at col 0, even mid-line.
        col_eff   = bus.s_tuser[0] ? '0 : col;
        line_end  = bus.s_tuser[1] | (col_eff == COL_W'(LINE_W - 1));
        win_full  = col_eff >= COL_W'(filter_size - 1);
        pend_next = pending_sof | bus.s_tuser[0];
        ws        = WS_W'(cs_win[0]) + WS_W'(cs_win[1]) + WS_W'(cs_win[2])
                  + WS_W'(cs_win[3]) + WS_W'(cs_win[4]);
`ifdef BOX5_CENTER_BYPASS_EN
        q_next    = s2_byp ? s2_ctr : pix_depth'(ws_r / WS_W'(25));
`else
        q_next    = pix_depth'(ws_r / WS_W'(25));
`endif
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            col         <= '0;
            pending_sof <= 1'b0;
            cs_win      <= '0;
            s1_valid    <= 1'b0;
            s1_user     <= '0;
            ws_r        <= '0;
            s2_valid    <= 1'b0;
            s2_user     <= '0;
            q_r         <= '0;
            s3_valid    <= 1'b0;
            s3_user     <= '0;
            m_data_r    <= '0;
            m_valid_r   <= 1'b0;
            m_user_r    <= '0;
`ifdef BOX5_CENTER_BYPASS_EN
            ctr_win     <= '0;
            s1_byp      <= 1'b0;
            s2_byp      <= 1'b0;
            s2_ctr      <= '0;
`endif
        end else if (en) begin
            s1_valid <= 1'b0;
            s1_user  <= '0;
            if (accept) begin
                cs_win      <= {cs_win[3:0], cs};
                col         <= line_end ? '0 : col_eff + COL_W'(1);
                s1_valid    <= win_full;
                s1_user     <= {line_end & win_full, pend_next & win_full};
                pending_sof <= pend_next & !win_full;
`ifdef BOX5_CENTER_BYPASS_EN
                ctr_win     <= {ctr_win[1:0], bus.in_d2};
                s1_byp      <= bus.bypass;
`endif
            end

            ws_r      <= ws;
            s2_valid  <= s1_valid;
            s2_user   <= s1_user;
`ifdef BOX5_CENTER_BYPASS_EN
            s2_ctr    <= ctr_win[2];
            s2_byp    <= s1_byp;
`endif

            q_r       <= q_next;
            s3_valid  <= s2_valid;
            s3_user   <= s2_user;

            m_data_r  <= q_r;
            m_valid_r <= s3_valid;
            m_user_r  <= s3_user;
        end
    end

    assign bus.s_tready = en;
    assign bus.m_tvalid = m_valid_r;
    assign bus.m_tdata  = m_data_r;
    assign bus.m_tuser  = m_user_r;

endmodule

// File: tb/tb_box5_window_filter.sv
// tb_box5_window_filter: directed column stimulus with a queue scoreboard and independent output monitor.
// Also exercises the BOX5_CENTER_BYPASS_EN build when that macro is defined.
module tb_box5_window_filter;
    localparam int PD = 4;
    localparam int FW = 10;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [5:0] exp_q[$];
    bit   mon_en = 1'b0;
    bit   bp_mode = 1'b0;
    int   bp_cnt = 0;
    bit   arm_lat = 1'b0;
    bit   lat_arm = 1'b0;
    int   lat_ref = 0;

    box5_window_filter_if #(.pix_depth(PD)) bus ();

`ifdef BOX5_CENTER_BYPASS_EN
    logic tb_byp = 1'b0;
    assign bus.bypass = tb_byp;
`endif

    box5_window_filter #(
        .pix_depth  (PD),
        .frame_width(FW),
        .filter_size(5)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    // downstream ready: always 1, or the repeating 1,0,0,1 pattern
    initial begin
        bus.m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                bus.m_tready = (bp_cnt % 4 == 0) || (bp_cnt % 4 == 3);
                bp_cnt++;
            end else begin
                bus.m_tready = 1'b1;
            end
        end
    end

    // output monitor / scoreboard
    initial begin
        bit         was_stall;
        logic [3:0] hold_data;
        logic [1:0] hold_user;
        logic [5:0] exp;
        was_stall = 1'b0;
        hold_data = '0;
        hold_user = '0;
        forever begin
            @(negedge clk);
            if (!mon_en || !resetn) begin
                was_stall = 1'b0;
            end else begin
                n_checks++;
                if (bus.s_tready !== (!bus.m_tvalid | bus.m_tready)) begin
                    n_fail++;
                    $display("FAIL s_tready: got %b want %b at cyc %0d", bus.s_tready,
                             !bus.m_tvalid | bus.m_tready, cyc);
                end
                if (was_stall) begin
                    n_checks++;
                    if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== hold_data || bus.m_tuser !== hold_user) begin
                        n_fail++;
                        $display("FAIL stall_hold: got v=%b d=%0d u=%b want v=1 d=%0d u=%b at cyc %0d",
                                 bus.m_tvalid, bus.m_tdata, bus.m_tuser, hold_data, hold_user, cyc);
                    end
                end
                was_stall = bus.m_tvalid & !bus.m_tready;
                hold_data = bus.m_tdata;
                hold_user = bus.m_tuser;
                if (bus.m_tvalid && lat_arm) begin
                    n_checks++;
                    lat_arm = 1'b0;
                    if (cyc - lat_ref != 3) begin
                        n_fail++;
                        $display("FAIL latency: got %0d clocks want 3", cyc - lat_ref);
                    end
                end
                if (bus.m_tvalid && bus.m_tready) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_output: got d=%0d u=%b want none at cyc %0d",
                                 bus.m_tdata, bus.m_tuser, cyc);
                    end else begin
                        exp = exp_q.pop_front();
                        if ({bus.m_tuser, bus.m_tdata} !== exp) begin
                            n_fail++;
                            $display("FAIL output: got d=%0d u=%b want d=%0d u=%b at cyc %0d",
                                     bus.m_tdata, bus.m_tuser, exp[3:0], exp[5:4], cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic push_exp(input int data, input bit sof, input bit eol);
        exp_q.push_back({eol, sof, 4'(data)});
    endtask

    task automatic send_col(input logic [19:0] d, input logic [1:0] user);
        int   t;
        logic rdy;
        bus.s_tvalid = 1'b1;
        bus.s_tuser  = user;
        bus.in_d0    = d[3:0];
        bus.in_d1    = d[7:4];
        bus.in_d2    = d[11:8];
        bus.in_d3    = d[15:12];
        bus.in_d4    = d[19:16];
        t = 0;
        forever begin
            @(negedge clk);
            rdy = bus.s_tready;
            @(posedge clk);
            #1;
            if (rdy) break;
            t++;
            if (t > 100) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout: got s_tready=0 for %0d cycles want 1", t);
                break;
            end
        end
    endtask

    // kind 0: all rows val; 1: ramp (all rows = column index); 2: only d0 = val; 3: only d2 = val
    task automatic send_line(input int ncols, input bit sof, input int kind, input logic [3:0] val);
        logic [19:0] d;
        logic [3:0]  kv;
        for (int k = 0; k < ncols; k++) begin
            kv = 4'(k);
            case (kind)
                0:       d = {5{val}};
                1:       d = {5{kv}};
                2:       d = {16'h0, val};
                default: d = {8'h0, val, 8'h0};
            endcase
            send_col(d, {k == ncols - 1, sof && k == 0});
            if (arm_lat && k == 4) begin
                lat_ref = cyc;
                lat_arm = 1'b1;
                arm_lat = 1'b0;
            end
        end
        bus.s_tvalid = 1'b0;
        bus.s_tuser  = '0;
    endtask

    task automatic push_line(input int first, input int step, input int n, input bit sof);
        for (int j = 0; j < n; j++) push_exp(first + step * j, sof && j == 0, j == n - 1);
    endtask

    task automatic drain;
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d outputs pending want 0", exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.s_tvalid = 1'b0;
        bus.s_tuser  = '0;
        bus.in_d0    = '0;
        bus.in_d1    = '0;
        bus.in_d2    = '0;
        bus.in_d3    = '0;
        bus.in_d4    = '0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.m_tvalid !== 1'b0 || bus.m_tdata !== 4'd0 || bus.m_tuser !== 2'd0 || bus.s_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b d=%0d u=%b rdy=%b want v=0 d=0 u=00 rdy=1",
                     bus.m_tvalid, bus.m_tdata, bus.m_tuser, bus.s_tready);
        end
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // flat frame of 7s, two lines; latency measured on the first window
        push_line(7, 0, 10, 1'b1);
        push_line(7, 0, 10, 1'b0);
        arm_lat = 1'b1;
        send_line(14, 1'b1, 0, 4'd7);
        send_line(14, 1'b0, 0, 4'd7);
        drain();

        // ramp: outputs 2..11
        push_line(2, 1, 10, 1'b1);
        send_line(14, 1'b1, 1, 4'd0);
        drain();

        // max value, then single bright row: 75/25 = 3
        push_line(15, 0, 10, 1'b1);
        send_line(14, 1'b1, 0, 4'd15);
        push_line(3, 0, 10, 1'b0);
        send_line(14, 1'b0, 2, 4'd15);
        drain();

        // backpressure on the ramp
        bp_mode = 1'b1;
        push_line(2, 1, 10, 1'b1);
        send_line(14, 1'b1, 1, 4'd0);
        drain();
        bp_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // early EOL at col 7 (4 outputs), full line, EOL at col 3 (none), full line
        push_line(2, 1, 4, 1'b1);
        send_line(8, 1'b1, 1, 4'd0);
        push_line(2, 1, 10, 1'b0);
        send_line(14, 1'b0, 1, 4'd0);
        send_line(4, 1'b0, 1, 4'd0);
        push_line(2, 1, 10, 1'b0);
        send_line(14, 1'b0, 1, 4'd0);
        drain();

        // reset mid-line with two windows in flight: nothing may emerge
        for (int k = 0; k < 6; k++) send_col({5{4'(k)}}, {1'b0, k == 0});
        bus.s_tvalid = 1'b0;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.m_tvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_valid: got %b want 0 at cycle %0d after reset", bus.m_tvalid, i);
            end
        end
        @(posedge clk);
        #1;
        push_line(2, 1, 10, 1'b1);
        send_line(14, 1'b1, 1, 4'd0);
        drain();

        // bright centre row only: average is 3
        push_line(3, 0, 10, 1'b1);
        send_line(14, 1'b1, 3, 4'd15);
        drain();

`ifdef BOX5_CENTER_BYPASS_EN
        tb_byp = 1'b1;
        push_line(2, 1, 10, 1'b1);
        send_line(14, 1'b1, 1, 4'd0);
        push_line(15, 0, 10, 1'b0);
        send_line(14, 1'b0, 0, 4'd15);
        push_line(15, 0, 10, 1'b0);
        send_line(14, 1'b0, 3, 4'd15);
        drain();
        tb_byp = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
